// File: rtl/mole_game_controller.sv
// Whack-a-mole game sequencer: start countdown, timed play with BCD score/time,
// hit masking per mole pattern, and a registered display/LED interface.
module mole_game_controller #(
  parameter int unsigned CD_SECS   = 5,
  parameter int unsigned GAME_SECS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        start,
  input  logic [4:0]  button_db,
  input  logic [4:0]  mole_leds,
  output logic [4:0]  led_out,
  output logic [31:0] display_value,
  output logic        game_active,
  output logic        game_over
);

  localparam int unsigned MOLES     = 5;
  localparam int unsigned GAME_TENS = GAME_SECS / 10;
  localparam int unsigned GAME_ONES = GAME_SECS % 10;
  localparam logic [7:0]  GAME_BCD  = {4'(GAME_TENS), 4'(GAME_ONES)};
  localparam logic [3:0]  CD_INIT   = 4'(CD_SECS);

  typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cd_q, cd_d;
  logic [7:0]         time_q, time_d;
  logic [7:0]         score_q, score_d;
  logic [MOLES-1:0]   hit_mask_q, hit_mask_d;
  logic               start_q, start_d;
  logic               start_arm_q, start_arm_d;
  logic [MOLES-1:0]   btn_q, btn_d;
  logic [MOLES-1:0]   mole_prev_q, mole_prev_d;
  logic [MOLES-1:0]   led_out_q, led_out_d;
  logic [31:0]        display_q, display_d;
  logic               game_active_q, game_active_d;
  logic               game_over_q, game_over_d;

  logic               start_edge;
  logic [MOLES-1:0]   btn_edge;
  logic [MOLES-1:0]   hits;
  logic               mole_changed;
  logic               enter_play;

  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)       return v;
    if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Next-state, datapath and next-output computation
  always_comb begin
    state_d     = state_q;
    cd_d        = cd_q;
    time_d      = time_q;
    score_d     = score_q;
    hit_mask_d  = hit_mask_q;
    enter_play  = 1'b0;

    // A start level held through reset release must be seen low before it can edge
    start_edge   = start & ~start_q & start_arm_q;
    btn_edge     = button_db & ~btn_q;
    mole_changed = (mole_leds != mole_prev_q);
    hits         = btn_edge & mole_prev_q & ~hit_mask_q;

    start_d     = start;
    start_arm_d = start_arm_q | ~start;
    btn_d       = button_db;
    mole_prev_d = mole_leds;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          state_d = S_COUNTDOWN;
          cd_d    = CD_INIT;
        end
      end
      S_COUNTDOWN: begin
        if (tick_1hz) begin
          if (cd_q == 4'd1) begin
            state_d    = S_PLAY;
            cd_d       = 4'd0;
            time_d     = GAME_BCD;
            score_d    = 8'h00;
            enter_play = 1'b1;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      S_PLAY: begin
        if (hits != '0) begin
          score_d    = bcd_inc_sat(score_q);
          hit_mask_d = hit_mask_q | hits;
        end
        if (tick_1hz) begin
          if (time_q == 8'h01) begin
            state_d = S_DONE;
            time_d  = 8'h00;
          end else begin
            time_d = bcd_dec(time_q);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new mole pattern overrides any hit marking made this cycle
    if (mole_changed || enter_play) hit_mask_d = '0;

    led_out_d     = (state_d == S_PLAY) ? (mole_leds & ~hit_mask_d) : '0;
    game_active_d = (state_d == S_PLAY);
    game_over_d   = (state_d == S_DONE);
    case (state_d)
      S_COUNTDOWN:    display_d = {28'h0, cd_d};
      S_PLAY, S_DONE: display_d = {8'h00, time_d, 8'h00, score_d};
      default:        display_d = 32'h0;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cd_q          <= '0;
      time_q        <= '0;
      score_q       <= '0;
      hit_mask_q    <= '0;
      start_q       <= 1'b0;
      start_arm_q   <= 1'b0;
      btn_q         <= '0;
      mole_prev_q   <= '0;
      led_out_q     <= '0;
      display_q     <= '0;
      game_active_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cd_q          <= cd_d;
      time_q        <= time_d;
      score_q       <= score_d;
      hit_mask_q    <= hit_mask_d;
      start_q       <= start_d;
      start_arm_q   <= start_arm_d;
      btn_q         <= btn_d;
      mole_prev_q   <= mole_prev_d;
      led_out_q     <= led_out_d;
      display_q     <= display_d;
      game_active_q <= game_active_d;
      game_over_q   <= game_over_d;
    end
  end

  assign led_out       = led_out_q;
  assign display_value = display_q;
  assign game_active   = game_active_q;
  assign game_over     = game_over_q;

endmodule

// File: doc/mole_game_controller.md
MOLE_GAME_CONTROLLER -- requirements
Module: mole_game_controller

Interface
REQ-001 Parameter CD_SECS, default 5, pre-game countdown length in seconds; legal range 1..9.
REQ-002 Parameter GAME_SECS, default 30, play length in seconds; legal range 1..99.
REQ-003 clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-005 tick_1hz  input  1  one-clk-wide enable pulse, once per second, synchronous to clk.
REQ-006 start  input  1  debounced start request, level; the block acts on its rising edge only.
REQ-007 button_db  input  5  debounced mole buttons, levels; the block acts on per-bit rising edges only.
REQ-008 mole_leds  input  5  current mole pattern from the random generator.
REQ-009 led_out  output  5  moles shown to the player.
REQ-010 display_value  output  32  8 BCD nibbles for the display controller; nibble 0 = bits [3:0].
REQ-011 game_active  output  1  high while in PLAY.
REQ-012 game_over  output  1  high while in DONE.

Function
REQ-013 The block SHALL have states IDLE, COUNTDOWN, PLAY and DONE.
REQ-014 The block SHALL register start and button_db, and SHALL form rising-edge pulses as current & ~previous.
REQ-015 In IDLE or DONE, a start edge SHALL move the block to COUNTDOWN with cd = CD_SECS; any tick_1hz in that same cycle SHALL be ignored.
REQ-016 In COUNTDOWN, each tick_1hz SHALL decrement cd.
REQ-017 In COUNTDOWN, a tick_1hz with cd == 1 SHALL move the block to PLAY, load the time to GAME_SECS in BCD, and clear the score to 00.
REQ-018 In PLAY, each tick_1hz SHALL BCD-decrement the time (ones 0 -> 9 with a tens borrow).
REQ-019 In PLAY, a tick_1hz with time == 01 SHALL move the block to DONE with time = 00.
REQ-020 Start edges in COUNTDOWN or PLAY SHALL be ignored.
REQ-021 hit_mask (5 bits) SHALL clear whenever mole_leds differs from its registered previous value, and on entry to PLAY.
REQ-022 visible SHALL equal mole_leds & ~hit_mask; led_out SHALL equal visible in PLAY and 0 in every other state.
REQ-023 In PLAY, when (button edges & visible) != 0, the score SHALL BCD-increment by exactly 1 per cycle, regardless of how many bits match.
REQ-024 In that same cycle, every matched bit SHALL be set in hit_mask, so each mole scores at most once.
REQ-025 Score arithmetic: ones 9 -> 0 with a tens carry; the score SHALL saturate at 99.
REQ-026 Button edges that match no visible mole SHALL leave the score unchanged (no penalty).
REQ-027 A hit in the same cycle as the final tick_1hz (REQ-019) SHALL be counted; a hit in DONE SHALL NOT be counted.
REQ-028 A mole_leds change in the same cycle as a hit SHALL take priority: hit_mask is cleared, and the hit still scores if it matched the pre-change visible value.
REQ-029 Display in IDLE: display_value = 0x0000_0000.
REQ-030 Display in COUNTDOWN: nibble 0 = cd; all other nibbles 0.
REQ-031 Display in PLAY and DONE: nibbles [1:0] = score; nibbles [5:4] = time; all other nibbles 0.
REQ-032 All outputs SHALL be registered and SHALL reflect a state change one clk after the causing edge.
REQ-033 The score SHALL be held through DONE and cleared only on the next entry to PLAY.

Reset
REQ-034 With reset low at a clk edge, the block SHALL enter IDLE and clear cd, time, score, hit_mask and all edge-detect registers.
REQ-035 Reset SHALL drive led_out = 0, display_value = 0, game_active = 0 and game_over = 0, including when asserted mid-COUNTDOWN or mid-PLAY.
REQ-036 After reset release, a start level already high SHALL NOT count as an edge until it has been seen low.

Verification
REQ-037 Start pulse, then 5 ticks -> display reads 5, 4, 3, 2, 1, then PLAY with display 0x0030_0000 and game_active = 1.
REQ-038 PLAY, mole_leds = 00100, button 2 pressed twice -> score 01 only; led_out goes 00100 -> 00000; mole_leds changes to 01000 -> led_out = 01000.
REQ-039 PLAY with score 99, another valid hit -> score stays 99; 30 ticks from PLAY entry -> DONE, display 0x0000_0099, game_over = 1, led_out = 0.
REQ-040 PLAY with time 01, tick_1hz and a valid hit in the same cycle -> score +1 and state DONE.
REQ-041 Reset low mid-PLAY with score 12 -> all outputs 0, state IDLE; start held high across reset release -> stays IDLE.
REQ-042 Buttons 0 and 3 pressed in the same cycle on mole_leds = 01001 -> score +1, led_out = 0; tick_1hz in the same cycle as a start edge in IDLE -> cd = 5, not 4.
